// File: rtl/iarray2p_init_pkg.sv
// Shared types and helpers for the two-port register array with post-reset clear.
package iarray_pkg;

  typedef enum logic [1:0] {
    CLR_IDLE  = 2'd0,
    CLR_CLEAR = 2'd1,
    CLR_DONE  = 2'd2
  } clr_state_t;

  // Per-lane write enable levels; the clear sweep drives every lane with LANE_WR.
  localparam logic LANE_KEEP = 1'b0;
  localparam logic LANE_WR   = 1'b1;

  function automatic int nlane(input int width, input int bytew);
    return width / bytew;
  endfunction

endpackage

// File: rtl/iarray2p_init_clrseq.sv
// Write-domain clear sequencer: sweeps zeros through every word after wrst_ and
// reports busy/done levels.
module iarray_clrseq
  import iarray_pkg::*;
#(
  parameter int DEPTH  = 512,
  parameter int AW     = 9,
  parameter bit CLR_EN = 1'b0
) (
  input  logic          wclk,
  input  logic          wrst_,
  output logic          clr_we,
  output logic [AW-1:0] clr_wa,
  output logic          init_busy,
  output logic          init_done
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  clr_state_t    state_reg, state_next;
  logic [AW-1:0] cnt_reg, cnt_next;

  always_ff @(posedge wclk or negedge wrst_) begin
    if (!wrst_) begin
      if (CLR_EN) state_reg <= CLR_CLEAR;
      else        state_reg <= CLR_DONE;
      cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      CLR_IDLE: begin
        cnt_next = '0;
        if (CLR_EN) state_next = CLR_CLEAR;
        else        state_next = CLR_DONE;
      end
      CLR_CLEAR: begin
        if (cnt_reg == LAST) state_next = CLR_DONE;
        else                 cnt_next   = cnt_reg + 1'b1;
      end
      CLR_DONE: ;
      default: state_next = CLR_IDLE;
    endcase
  end

  assign clr_we    = (state_reg == CLR_CLEAR);
  assign clr_wa    = cnt_reg;
  assign init_busy = (state_reg == CLR_CLEAR);
  assign init_done = (state_reg == CLR_DONE);

endmodule

// File: rtl/iarray2p_init.sv
// Two-port register-array RAM: lane-masked writes on wclk, registered reads on rclk
// with 1 or 2 cycle latency, optional zero sweep after wrst_ and synchronised done.
module iarray2p_init
  import iarray_pkg::*;
#(
  parameter int    ADDRBIT   = 9,
  parameter int    DEPTH     = 512,
  parameter int    WIDTH     = 8,
  parameter int    BYTEW     = WIDTH,
  parameter int    RDLAT     = 1,
  parameter string MEM_RESET = "OFF"
) (
  input  logic                           rclk,
  input  logic                           rrst_,
  input  logic                           wclk,
  input  logic                           wrst_,
  input  logic [ADDRBIT-1:0]             wa,
  input  logic                           we,
  input  logic [nlane(WIDTH, BYTEW)-1:0] wbe,
  input  logic [WIDTH-1:0]               di,
  input  logic [ADDRBIT-1:0]             ra,
  input  logic                           re,
  output logic [WIDTH-1:0]               dout,
  output logic                           rvld,
  output logic                           init_busy,
  output logic                           rinit_done,
  input  logic                           test,
  input  logic                           mask
);

  localparam int               NLANE     = nlane(WIDTH, BYTEW);
  localparam int               AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam bit               CLR_EN    = (MEM_RESET == "ON");
  localparam logic [ADDRBIT:0] DEPTH_LIM = (ADDRBIT + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic             clr_we;
  logic [AW-1:0]    clr_wa;
  logic             init_done;
  logic             user_we;
  logic             wr_en;
  logic [AW-1:0]    wr_idx;
  logic [WIDTH-1:0] wr_data;
  logic [NLANE-1:0] wr_be;
  logic             rd_ok;
  logic [WIDTH-1:0] s1_data_reg;
  logic             s1_vld_reg;
  logic             sync1_reg, sync2_reg;

  iarray_clrseq #(
    .DEPTH  (DEPTH),
    .AW     (AW),
    .CLR_EN (CLR_EN)
  ) u_clrseq (
    .wclk      (wclk),
    .wrst_     (wrst_),
    .clr_we    (clr_we),
    .clr_wa    (clr_wa),
    .init_busy (init_busy),
    .init_done (init_done)
  );

  // The sweep owns the write port while busy, so user writes simply lose.
  always_comb begin
    user_we = we & ({1'b0, wa} < DEPTH_LIM) & ~init_busy & ~(test & mask);
    wr_en   = clr_we | user_we;
    if (clr_we) begin
      wr_idx  = clr_wa;
      wr_data = '0;
      wr_be   = {NLANE{LANE_WR}};
    end else begin
      wr_idx  = wa[AW-1:0];
      wr_data = di;
      wr_be   = wbe;
    end
  end

  always_ff @(posedge wclk) begin
    if (wr_en) begin
      for (int i = 0; i < NLANE; i++) begin
        if (wr_be[i] != LANE_KEEP) mem[wr_idx][i*BYTEW +: BYTEW] <= wr_data[i*BYTEW +: BYTEW];
      end
    end
  end

  assign rd_ok = ({1'b0, ra} < DEPTH_LIM) & rinit_done & ~(test & mask);

  always_ff @(posedge rclk or negedge rrst_) begin
    if (!rrst_) begin
      s1_data_reg <= '0;
      s1_vld_reg  <= 1'b0;
    end else begin
      s1_vld_reg <= re;
      if (re) s1_data_reg <= rd_ok ? mem[ra[AW-1:0]] : '0;
    end
  end

  generate
    if (RDLAT == 2) begin : g_lat2
      logic [WIDTH-1:0] s2_data_reg;
      logic             s2_vld_reg;

      always_ff @(posedge rclk or negedge rrst_) begin
        if (!rrst_) begin
          s2_data_reg <= '0;
          s2_vld_reg  <= 1'b0;
        end else begin
          s2_vld_reg <= s1_vld_reg;
          if (s1_vld_reg) s2_data_reg <= s1_data_reg;
        end
      end

      assign dout = s2_data_reg;
      assign rvld = s2_vld_reg;
    end else begin : g_lat1
      assign dout = s1_data_reg;
      assign rvld = s1_vld_reg;
    end
  endgenerate

  // Done is a slow level from the write domain; two flops are enough to land it.
  always_ff @(posedge rclk or negedge rrst_) begin
    if (!rrst_) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= init_done;
      sync2_reg <= sync1_reg;
    end
  end

  assign rinit_done = sync2_reg;

endmodule

// File: tb/tb_iarray2p_init.sv
// Self-checking bench: behavioural memory/sweep/read-queue model compared every
// cycle, plus hand-computed literal checks on the directed scenarios.
module tb_iarray2p_init;

  localparam int ADDRBIT = 5;
  localparam int DEPTH   = 16;
  localparam int WIDTH   = 16;
  localparam int BYTEW   = 8;
  localparam int NLANE   = 2;
  localparam int RDLAT   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rrst_ = 1'b0, wrst_ = 1'b0;
  logic               we = 1'b0, re = 1'b0, test = 1'b0, mask = 1'b0;
  logic [ADDRBIT-1:0] wa = '0, ra = '0;
  logic [NLANE-1:0]   wbe = '0;
  logic [WIDTH-1:0]   di = '0;
  logic [WIDTH-1:0]   dout;
  logic               rvld, init_busy, rinit_done;

  iarray2p_init #(
    .ADDRBIT   (ADDRBIT),
    .DEPTH     (DEPTH),
    .WIDTH     (WIDTH),
    .BYTEW     (BYTEW),
    .RDLAT     (RDLAT),
    .MEM_RESET ("ON")
  ) dut (
    .rclk       (clk),
    .rrst_      (rrst_),
    .wclk       (clk),
    .wrst_      (wrst_),
    .wa         (wa),
    .we         (we),
    .wbe        (wbe),
    .di         (di),
    .ra         (ra),
    .re         (re),
    .dout       (dout),
    .rvld       (rvld),
    .init_busy  (init_busy),
    .rinit_done (rinit_done),
    .test       (test),
    .mask       (mask)
  );

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  // Behavioural model: a word array, a count of words still to clear, a queue
  // of reads with their due cycle, and a history of the done level.
  typedef struct {
    int               due;
    logic [WIDTH-1:0] data;
  } rd_t;

  logic [WIDTH-1:0] mem_m [DEPTH];
  int               sweep_left = DEPTH;
  int               ecount = 0;
  rd_t              rq[$];
  rd_t              rent;
  bit               dhist[$];
  logic [WIDTH-1:0] exp_do = '0;
  logic             exp_rvld = 1'b0, exp_busy = 1'b1, exp_rinit = 1'b0;
  logic             rin_prev, done_before;

  always @(posedge clk) begin
    ecount++;
    rin_prev    = exp_rinit;
    done_before = wrst_ && (sweep_left == 0);
    if (!rrst_) begin
      rq.delete();
      dhist.delete();
      exp_do    = '0;
      exp_rvld  = 1'b0;
      exp_rinit = 1'b0;
    end else begin
      if (re) begin
        rent.due  = ecount + RDLAT - 1;
        rent.data = (int'(ra) < DEPTH && rin_prev && !(test && mask)) ? mem_m[ra[3:0]] : '0;
        rq.push_back(rent);
      end
      exp_rvld = 1'b0;
      if (rq.size() > 0 && rq[0].due == ecount) begin
        exp_rvld = 1'b1;
        exp_do   = rq[0].data;
        void'(rq.pop_front());
      end
      dhist.push_back(done_before);
      if (dhist.size() > 4) void'(dhist.pop_front());
      exp_rinit = (dhist.size() >= 2) ? dhist[dhist.size()-2] : 1'b0;
    end
    if (!wrst_) begin
      sweep_left = DEPTH;
    end else if (sweep_left > 0) begin
      mem_m[DEPTH - sweep_left] = '0;
      sweep_left--;
    end else if (we && int'(wa) < DEPTH && !(test && mask)) begin
      for (int l = 0; l < NLANE; l++)
        if (wbe[l]) mem_m[wa[3:0]][l*BYTEW +: BYTEW] = di[l*BYTEW +: BYTEW];
    end
    exp_busy = (sweep_left > 0);
  end

  // Resets act asynchronously, so their effect is applied here before the model catches up.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("rvld",       {31'b0, rvld},       rrst_ ? {31'b0, exp_rvld}  : 32'd0);
      chk("dout",       {16'b0, dout},       rrst_ ? {16'b0, exp_do}    : 32'd0);
      chk("init_busy",  {31'b0, init_busy},  wrst_ ? {31'b0, exp_busy}  : 32'd1);
      chk("rinit_done", {31'b0, rinit_done}, rrst_ ? {31'b0, exp_rinit} : 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input int a, input logic [15:0] d, input logic [1:0] be);
    wa  = ADDRBIT'(a);
    di  = d;
    wbe = be;
    we  = 1'b1;
    step();
    we  = 1'b0;
  endtask

  task automatic rd_lit(input int a, input logic [15:0] expv, input string nm);
    int k;
    ra = ADDRBIT'(a);
    re = 1'b1;
    step();
    re = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!rvld && k < 6);
    chk({nm, "_rvld"}, {31'b0, rvld}, 32'd1);
    chk(nm, {16'b0, dout}, {16'b0, expv});
  endtask

  task automatic count_busy(output int n);
    n = 0;
    @(negedge clk);
    while (init_busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_rinit(output int n);
    n = 0;
    while (!rinit_done && n < 10) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) begin
      ra = ADDRBIT'(a);
      re = 1'b1;
      step();
    end
    re = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    int n;
    repeat (3) step();
    rrst_  = 1'b1;
    wrst_  = 1'b1;
    chk_en = 1'b1;

    // Power-up sweep and done crossing.
    count_busy(n);
    chk("sweep_len", n, 16);
    wait_rinit(n);
    chk("rinit_lat", n, 2);
    read_all();

    // Byte-lane merge.
    wr(3, 16'hA55A, 2'b11);
    wr(3, 16'hFF00, 2'b10);
    rd_lit(3, 16'hFF5A, "lane_merge");

    // Two-cycle latency, back-to-back, then hold.
    wr(1, 16'h1111, 2'b11);
    wr(2, 16'h2222, 2'b11);
    for (int a = 1; a <= 3; a++) begin
      ra = ADDRBIT'(a);
      re = 1'b1;
      step();
    end
    re = 1'b0;
    @(negedge clk);
    chk("lat_addr2", {16'b0, dout}, 32'h2222);
    @(negedge clk);
    chk("lat_addr3", {16'b0, dout}, 32'hFF5A);
    chk("lat_addr3_vld", {31'b0, rvld}, 32'd1);
    @(negedge clk);
    chk("hold_vld", {31'b0, rvld}, 32'd0);
    chk("hold_data", {16'b0, dout}, 32'hFF5A);

    // Out-of-range addresses.
    wr(16, 16'hBEEF, 2'b11);
    rd_lit(0, 16'h0000, "wa_oob");
    rd_lit(16, 16'h0000, "ra_oob");

    // Garbage, then a reset sweep with a write attempted while busy.
    for (int a = 0; a < DEPTH; a++) wr(a, {a[7:0] ^ 8'hA5, a[7:0]}, 2'b11);
    rd_lit(7, 16'hA207, "garbage");
    step();
    wrst_ = 1'b0;
    repeat (2) step();
    wrst_ = 1'b1;
    wr(5, 16'hDEAD, 2'b11);
    n = 0;
    while (init_busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("sweep2_end", {31'b0, init_busy}, 32'd0);
    wait_rinit(n);
    chk("rinit2", {31'b0, rinit_done}, 32'd1);
    step();
    read_all();
    rd_lit(5, 16'h0000, "wr_during_busy");

    // Reset at cnt=7 restarts the full sweep.
    step();
    wrst_ = 1'b0;
    step();
    wrst_ = 1'b1;
    repeat (7) step();
    wrst_ = 1'b0;
    step();
    wrst_ = 1'b1;
    count_busy(n);
    chk("sweep_restart", n, 16);
    wait_rinit(n);
    chk("rinit3", {31'b0, rinit_done}, 32'd1);

    // Read reset while a read is in flight.
    wr(4, 16'h4444, 2'b11);
    rd_lit(4, 16'h4444, "pre_rrst");
    ra = ADDRBIT'(4);
    re = 1'b1;
    step();
    re = 1'b0;
    rrst_ = 1'b0;
    @(negedge clk);
    chk("rrst_dout", {16'b0, dout}, 32'd0);
    step();
    rrst_ = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_rvld_after_rrst", {31'b0, rvld}, 32'd0);
    end
    rd_lit(4, 16'h4444, "post_rrst");

    // Test mask.
    wr(6, 16'h1234, 2'b11);
    test = 1'b1;
    mask = 1'b1;
    wr(6, 16'h005A, 2'b11);
    rd_lit(6, 16'h0000, "mask_read");
    test = 1'b0;
    mask = 1'b0;
    rd_lit(6, 16'h1234, "unmask_read");

    repeat (3) step();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
    $fatal(1);
  end

endmodule
